mul8_share_arbiter: RTL and testbench
=====================================

# mul8_share_arbiter

Shares one combinational 4x4 multiplier between up to four requesters. Each requester submits an 8x8 unsigned multiply. The block computes the result as four sequenced partial products into a 16-bit accumulator and returns the product tagged with the requester id. It sits between the Monte-Carlo sampling engines and the single area-limited multiplier, and replaces per-engine ad-hoc sequencing of the shared unit.

## Interface
Parameters:
- NREQ, 2, number of requesters; supported range 2..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  operand B; same packing as req_a.
- rsp_valid  out  1  one-cycle pulse; product is available.
- rsp_id  out  2  index of the requester that owns rsp_prod.
- rsp_prod  out  16  unsigned product a*b.
- busy  out  1  high in MUL and DONE states.

## Operation
- **States:** IDLE, MUL, DONE. A 2-bit phase counter runs inside MUL.
- **Arbitration:** round-robin. The rr pointer holds the highest-priority index; the search wraps from rr upward modulo NREQ.
  - The winner is the first requester with req_valid set.
  - req_ready[winner]=1 is driven combinationally, only in IDLE or DONE.
  - After a handshake, rr <= winner+1 (mod NREQ).
- **Handshake:** capture occurs on req_valid[i] & req_ready[i] at the clock edge.
  - Operands and id are latched into internal registers.
  - State goes to MUL with phase=0.
  - A requester must hold valid and operands stable until it is accepted. Valid must not depend on ready.
- **MUL phases** (mul4 inputs → accumulator update):
  - phase 0: a[3:0]*b[3:0]; acc <= pp.
  - phase 1: a[3:0]*b[7:4]; acc <= acc + (pp<<4).
  - phase 2: a[7:4]*b[3:0]; acc <= acc + (pp<<4).
  - phase 3: a[7:4]*b[7:4]; acc <= acc + (pp<<8). State then goes to DONE.
- **Width:** pp is 8 bits and acc is 16 bits. There is no overflow, since 255*255=0xFE01 fits in 16 bits.
- **DONE:**
  - rsp_valid=1; rsp_prod and rsp_id are registered outputs.
  - A new handshake in DONE goes directly to MUL. Otherwise the state returns to IDLE.
  - rsp_prod and rsp_id hold their values until the next DONE.
- **Multiplier input gating:** mul4 inputs are zero outside MUL, which avoids needless toggling.
- **Reset values:** req_ready=0 when no requester is valid. rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0, state=IDLE, rr=0.
- **Reset mid-operation:** the operation is aborted and no rsp_valid is issued. Captured operands are discarded. After reset, requester 0 has priority.

## Timing
- Handshake at edge T → rsp_valid high during cycle T+5 (4 MUL cycles plus DONE).
- Back-to-back accepts are 5 cycles apart when a new request is taken in DONE.
- Accepts are 6 cycles apart if the block passes through IDLE.
- req_ready is combinational from state, rr and req_valid. All other outputs are registered.
- Starvation bound: with NREQ requesters continuously valid, each is served within NREQ grants.

## Structure
- **Package mul8_arb_pkg:**
  - state enum {IDLE, MUL, DONE}.
  - localparam NPHASE=4.
  - localparam PP_W=8, ACC_W=16.
- **Sub-module mul4_unit:** combinational 4x4 → 8-bit unsigned multiplier, instantiated once.
- Arbiter logic, FSM and accumulator stay in the top module.

## Test plan
- **Single product:** requester 0 sends a=0x12, b=0x34 → rsp_prod=0x03A8, rsp_id=0, rsp_valid 5 cycles after the handshake.
- **Corner products:**
  - 0xFF*0xFF → 0xFE01.
  - 0x00*0xAB → 0x0000.
  - 0x80*0x02 → 0x0100.
- **Round-robin:** NREQ=2 with both requesters held valid from reset → grant/rsp_id sequence 0,1,0,1. Successive rsp_valid pulses are 5 cycles apart.
- **Wrap and skip:** NREQ=4, rr=3, requesters 1 and 3 valid → 3 is granted, then 1. rr=2 after the second grant.
- **Reset mid-operation:** assert rst in MUL phase 2 → no rsp_valid, busy=0, rsp_prod=0. The next request from requester 1 with a=0x0F, b=0x0F completes with 0x00E1.
- **Handshake discipline:** ready is never asserted to two requesters at once, and is never asserted during MUL. A requester holding valid through MUL keeps its operands, and its product is correct when it is served.

Source files
------------

// File: rtl/mul8_share_arbiter_pkg.sv
// Shared types and constants for the shared 4x4 multiplier arbiter.
package mul8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NPHASE = 4;
  localparam int PP_W   = 8;
  localparam int ACC_W  = 16;

  // Aligns a 4x4 partial product to its weight in the 8x8 result.
  function automatic logic [ACC_W-1:0] pp_shift(input logic [PP_W-1:0] pp,
                                                input logic [1:0]      phase);
    case (phase)
      2'd0:    pp_shift = {8'b0, pp};
      2'd1,
      2'd2:    pp_shift = {4'b0, pp, 4'b0};
      default: pp_shift = {pp, 8'b0};
    endcase
  endfunction

endpackage

// File: rtl/mul8_share_arbiter_if.sv
// Request/response bundle between the sampling engines and the arbiter.
interface mul8_share_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_prod;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_prod, busy
  );
endinterface

// File: rtl/mul8_share_arbiter_mul4.sv
// The single area-limited 4x4 unsigned multiplier.
module mul4_unit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = 8'(i_a) * 8'(i_b);

endmodule

// File: rtl/mul8_share_arbiter.sv
// Round-robin sharing of one 4x4 multiplier; each 8x8 product is built
// from four sequenced partial products into a 16-bit accumulator.
//
// state | meaning
// IDLE  | no operation, may accept a request
// MUL   | four partial-product phases in progress
// DONE  | result valid for one cycle, may accept the next request
module mul8_share_arbiter
  import mul8_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic                  clk,
  input logic                  rst,
  mul8_share_arbiter_if.slave  io_bus
);

  localparam int              PH_W    = $clog2(NPHASE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);
  localparam logic [1:0]      ST_IDLE = IDLE;
  localparam logic [1:0]      ST_MUL  = MUL;
  localparam logic [1:0]      ST_DONE = DONE;

  logic [1:0]       r_state;
  logic [1:0]       r_rr;
  logic [PH_W-1:0]  r_phase;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [1:0]       r_id;
  logic [ACC_W-1:0] r_acc;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_id;
  logic [ACC_W-1:0] r_rsp_prod;
  logic             r_busy;

  logic             w_found;
  logic [1:0]       w_win;
  logic [NREQ-1:0]  w_ready;
  logic             w_accept;
  logic [7:0]       w_win_a;
  logic [7:0]       w_win_b;
  logic [1:0]       w_rr_next;
  logic [3:0]       w_mul_a;
  logic [3:0]       w_mul_b;
  logic [PP_W-1:0]  w_pp;
  logic [ACC_W-1:0] w_acc_next;

  // Round-robin search starting at the priority pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && io_bus.req_valid[(int'(r_rr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = 2'((int'(r_rr) + k) % NREQ);
      end
    end
  end

  // Grant only where a new capture is possible; never during MUL.
  always_comb begin
    w_ready = '0;
    if (w_found && (r_state == ST_IDLE || r_state == ST_DONE)) begin
      w_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    end
  end

  assign w_accept  = |(io_bus.req_valid & w_ready);
  assign w_win_a   = io_bus.req_a[int'(w_win)*8 +: 8];
  assign w_win_b   = io_bus.req_b[int'(w_win)*8 +: 8];
  assign w_rr_next = 2'((int'(w_win) + 1) % NREQ);

  // Nibble select per phase; inputs held at zero outside MUL to stop toggling.
  always_comb begin
    w_mul_a = 4'd0;
    w_mul_b = 4'd0;
    if (r_state == ST_MUL) begin
      w_mul_a = r_phase[1] ? r_a[7:4] : r_a[3:0];
      w_mul_b = r_phase[0] ? r_b[7:4] : r_b[3:0];
    end
  end

  mul4_unit u_mul4 (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_pp)
  );

  // Phase 0 starts a fresh sum rather than adding onto a stale accumulator.
  assign w_acc_next = ((r_phase == '0) ? '0 : r_acc) + pp_shift(w_pp, r_phase);

  // Sequencer: capture, four accumulate phases, registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= 2'd0;
      r_phase     <= '0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_id        <= 2'd0;
      r_acc       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 2'd0;
      r_rsp_prod  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_MUL: begin
          r_acc   <= w_acc_next;
          r_phase <= r_phase + PH_W'(1);
          if (r_phase == PH_LAST) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_prod  <= w_acc_next;
            r_rsp_id    <= r_id;
          end
        end
        default: begin
          if (w_accept) begin
            r_a     <= w_win_a;
            r_b     <= w_win_b;
            r_id    <= w_win;
            r_rr    <= w_rr_next;
            r_phase <= '0;
            r_state <= ST_MUL;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_rsp_id;
  assign io_bus.rsp_prod  = r_rsp_prod;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Bench for mul8_share_arbiter: one NREQ=2 and one NREQ=4 instance share
// clock and reset; a select steers the requester stimulus to one of them.
module tb_mul8_share_arbiter;

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel4;
  logic [3:0] v_valid;
  logic [7:0] v_a [4];
  logic [7:0] v_b [4];

  int   checks   = 0;
  int   failures = 0;
  int   m_rr [2];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  mul8_share_arbiter_if #(.NREQ(2)) if2 ();
  mul8_share_arbiter_if #(.NREQ(4)) if4 ();

  mul8_share_arbiter #(.NREQ(2)) u_dut2 (.clk(clk), .rst(rst), .io_bus(if2.slave));
  mul8_share_arbiter #(.NREQ(4)) u_dut4 (.clk(clk), .rst(rst), .io_bus(if4.slave));

  assign if2.req_valid = sel4 ? 2'b00 : v_valid[1:0];
  assign if4.req_valid = sel4 ? v_valid : 4'b0000;
  assign if2.req_a = {v_a[1], v_a[0]};
  assign if2.req_b = {v_b[1], v_b[0]};
  assign if4.req_a = {v_a[3], v_a[2], v_a[1], v_a[0]};
  assign if4.req_b = {v_b[3], v_b[2], v_b[1], v_b[0]};

  wire [3:0]  o_ready     = sel4 ? if4.req_ready : {2'b00, if2.req_ready};
  wire        o_rsp_valid = sel4 ? if4.rsp_valid : if2.rsp_valid;
  wire [1:0]  o_rsp_id    = sel4 ? if4.rsp_id    : if2.rsp_id;
  wire [15:0] o_rsp_prod  = sel4 ? if4.rsp_prod  : if2.rsp_prod;
  wire        o_busy      = sel4 ? if4.busy      : if2.busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Grant exclusivity and no grant while multiplying, on both instances.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("ready_onehot_n2", 32'($onehot0(if2.req_ready)), 1);
      chk("ready_onehot_n4", 32'($onehot0(if4.req_ready)), 1);
      if (if2.busy && !if2.rsp_valid) chk("ready_in_mul_n2", 32'(if2.req_ready), 0);
      if (if4.busy && !if4.rsp_valid) chk("ready_in_mul_n4", 32'(if4.req_ready), 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_valid = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_rr[0] = 0;
    m_rr[1] = 0;
    exp_q.delete();
  endtask

  // Raise all requesters in mask at once; each drops valid once accepted.
  // Expected grant order: ascending distance from the model's rr pointer.
  task automatic run_set(input bit s4, input logic [3:0] mask);
    int         nq;
    int         cyc;
    logic [3:0] pend;
    logic [3:0] g;
    int         want [$];
    int         got [$];
    exp_t       e;
    nq = s4 ? 4 : 2;
    for (int k = 0; k < nq; k++)
      if (mask[(m_rr[s4] + k) % nq]) want.push_back((m_rr[s4] + k) % nq);
    @(negedge clk);
    sel4 = s4;
    v_valid = mask;
    pend = 4'b0;
    cyc = 0;
    while ((got.size() < want.size() || exp_q.size() != 0) && cyc < 200) begin
      v_valid = v_valid & ~pend;
      pend = 4'b0;
      #1;
      if (o_rsp_valid) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(o_rsp_id), e.id);
          chk("rsp_prod", 32'(o_rsp_prod), 32'(e.prod));
          chk("rsp_latency", cyc, e.due);
        end
      end
      g = o_ready & v_valid;
      if (g != 4'b0) begin
        for (int i = 0; i < 4; i++)
          if (g[i]) begin
            got.push_back(i);
            exp_q.push_back('{i, 16'(v_a[i]) * 16'(v_b[i]), cyc + 5});
          end
        pend = g;
      end
      @(negedge clk);
      cyc++;
    end
    chk("run_in_time", 32'(cyc < 200), 1);
    chk("grant_count", got.size(), want.size());
    for (int k = 0; k < want.size() && k < got.size(); k++)
      chk("grant_order", got[k], want[k]);
    if (want.size() != 0) m_rr[s4] = (want[want.size()-1] + 1) % nq;
    v_valid = 4'b0;
  endtask

  initial begin
    int         n;
    int         cyc;
    int         last;
    int         exp_id;
    bit         seen;
    logic [3:0] mask;
    bit         s4;

    rst = 1'b1;
    sel4 = 1'b0;
    v_valid = 4'b0;
    for (int i = 0; i < 4; i++) begin
      v_a[i] = 8'h00;
      v_b[i] = 8'h00;
    end
    m_rr[0] = 0;
    m_rr[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid_n2", 32'(if2.rsp_valid), 0);
    chk("reset_rsp_id_n2",    32'(if2.rsp_id), 0);
    chk("reset_rsp_prod_n2",  32'(if2.rsp_prod), 0);
    chk("reset_busy_n2",      32'(if2.busy), 0);
    chk("reset_ready_n2",     32'(if2.req_ready), 0);
    chk("reset_rsp_valid_n4", 32'(if4.rsp_valid), 0);
    chk("reset_busy_n4",      32'(if4.busy), 0);
    chk("reset_ready_n4",     32'(if4.req_ready), 0);
    rst = 1'b0;

    // Single product from requester 0.
    v_a[0] = 8'h12; v_b[0] = 8'h34;
    run_set(1'b0, 4'b0001);
    chk("single_prod", 32'(o_rsp_prod), 32'h03A8);
    chk("single_id",   32'(o_rsp_id), 0);

    // Corner products.
    v_a[1] = 8'hFF; v_b[1] = 8'hFF;
    run_set(1'b0, 4'b0010);
    chk("corner_ff_ff", 32'(o_rsp_prod), 32'hFE01);
    v_a[2] = 8'h00; v_b[2] = 8'hAB;
    run_set(1'b1, 4'b0100);
    chk("corner_00_ab", 32'(o_rsp_prod), 32'h0000);
    v_a[3] = 8'h80; v_b[3] = 8'h02;
    run_set(1'b1, 4'b1000);
    chk("corner_80_02", 32'(o_rsp_prod), 32'h0100);

    // Both requesters of the NREQ=2 instance held valid from reset.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v_a[i] = 8'($urandom);
      v_b[i] = 8'($urandom);
    end
    sel4 = 1'b0;
    @(negedge clk);
    v_valid = 4'b0011;
    n = 0; cyc = 0; last = 0;
    while (n < 4 && cyc < 100) begin
      #1;
      if (o_rsp_valid) begin
        exp_id = m_rr[0];
        m_rr[0] = (m_rr[0] + 1) % 2;
        chk("rr_id", 32'(o_rsp_id), exp_id);
        chk("rr_prod", 32'(o_rsp_prod), 32'(16'(v_a[exp_id]) * 16'(v_b[exp_id])));
        chk("rr_spacing", cyc - last, 5);
        last = cyc;
        n++;
        if (n == 4) v_valid = 4'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_count", n, 4);
    v_valid = 4'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("rr_drained", 32'(o_busy), 0);

    // Wrap and skip on NREQ=4: bring rr to 3, then 1 and 3 valid, then 0 and 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v_a[i] = 8'($urandom);
      v_b[i] = 8'($urandom);
    end
    run_set(1'b1, 4'b0100);
    run_set(1'b1, 4'b1010);
    run_set(1'b1, 4'b0101);

    // Reset during MUL phase 2 of a requester-0 operation.
    do_reset();
    sel4 = 1'b0;
    v_a[0] = 8'h5A; v_b[0] = 8'hC3;
    @(negedge clk);
    v_valid = 4'b0001;
    #1;
    chk("abort_ready", 32'(o_ready), 1);
    @(negedge clk);
    v_valid = 4'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_busy_before", 32'(o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rr[0] = 0;
    m_rr[1] = 0;
    exp_q.delete();
    #1;
    chk("abort_busy",      32'(o_busy), 0);
    chk("abort_rsp_prod",  32'(o_rsp_prod), 0);
    chk("abort_rsp_valid", 32'(o_rsp_valid), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (o_rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 0);
    v_a[0] = 8'($urandom); v_b[0] = 8'($urandom);
    v_a[1] = 8'h0F;        v_b[1] = 8'h0F;
    run_set(1'b0, 4'b0011);
    chk("after_abort_prod", 32'(o_rsp_prod), 32'h00E1);
    chk("after_abort_id",   32'(o_rsp_id), 1);

    // Randomised request sets on either instance.
    for (int t = 0; t < 30; t++) begin
      s4 = 1'($urandom);
      mask = s4 ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        v_a[i] = 8'($urandom);
        v_b[i] = 8'($urandom);
      end
      run_set(s4, mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
